insn_fetch_sequencer: RTL and testbench

Front-end controller between the prefetch byte FIFO and the ModRM decoder. Pops the opcode byte, classifies it through an external opcode-attribute ROM, then starts the ModRM decoder and hands it the FIFO read port. Afterwards it collects 0/1/2 immediate bytes and presents one instruction record to the microcode sequencer over a valid/ready handshake. It is the sole owner and arbiter of the FIFO read port.

---
 rtl/insn_fetch_sequencer_pkg.sv | 58 +++++
 rtl/insn_fetch_sequencer_if.sv | 43 ++++
 rtl/insn_fetch_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_insn_fetch_sequencer.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/insn_fetch_sequencer_pkg.sv
// Shared types for the instruction fetch sequencer: FSM states,
// immediate sizing, and segment-prefix opcodes/encodings.
package insn_fetch_sequencer_pkg;

    localparam int IMM_MAX_BYTES = 2;
    localparam int IMM_CNT_W     = $clog2(IMM_MAX_BYTES + 1);
    localparam int IMM_W         = 8 * IMM_MAX_BYTES;

    typedef logic [IMM_CNT_W-1:0] imm_cnt_t;

    localparam imm_cnt_t IMM_MAX = imm_cnt_t'(IMM_MAX_BYTES);

    typedef enum logic [2:0] {
        FETCH_OP,
        WAIT_OP,
        CLASSIFY,
        MODRM,
        IMM,
        DONE
    } fsm_state_e;

    // Encoding matches the segment register file index
    typedef enum logic [1:0] {
        SEG_ES = 2'd0,
        SEG_CS = 2'd1,
        SEG_SS = 2'd2,
        SEG_DS = 2'd3
    } seg_e;

    localparam logic [7:0] PFX_ES = 8'h26;
    localparam logic [7:0] PFX_CS = 8'h2E;
    localparam logic [7:0] PFX_SS = 8'h36;
    localparam logic [7:0] PFX_DS = 8'h3E;

    function automatic imm_cnt_t clamp_imm(input logic [1:0] n);
        imm_cnt_t c;
        c = imm_cnt_t'(n);
        return (c > IMM_MAX) ? IMM_MAX : c;
    endfunction

    function automatic logic is_seg_prefix(input logic [7:0] b);
        return (b == PFX_ES) || (b == PFX_CS) ||
               (b == PFX_SS) || (b == PFX_DS);
    endfunction

    function automatic seg_e prefix_seg(input logic [7:0] b);
        seg_e s;
        s = SEG_DS;
        case (b)
            PFX_ES:  s = SEG_ES;
            PFX_CS:  s = SEG_CS;
            PFX_SS:  s = SEG_SS;
            default: s = SEG_DS;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/insn_fetch_sequencer_if.sv
// Instruction record handshake toward the microcode sequencer.
// PREFIX_EN adds the segment-override fields.
interface insn_fetch_sequencer_if;
    import insn_fetch_sequencer_pkg::*;

    logic             insn_valid;
    logic             insn_ready;
    logic [7:0]       insn_opcode;
    logic             insn_has_modrm;
    logic [IMM_W-1:0] insn_imm;
    logic [1:0]       insn_imm_bytes;
`ifdef PREFIX_EN
    logic             insn_seg_valid;
    seg_e             insn_seg;
`endif

    modport master (
`ifdef PREFIX_EN
        output insn_seg_valid,
        output insn_seg,
`endif
        output insn_valid,
        output insn_opcode,
        output insn_has_modrm,
        output insn_imm,
        output insn_imm_bytes,
        input  insn_ready
    );

    modport slave (
`ifdef PREFIX_EN
        input  insn_seg_valid,
        input  insn_seg,
`endif
        input  insn_valid,
        input  insn_opcode,
        input  insn_has_modrm,
        input  insn_imm,
        input  insn_imm_bytes,
        output insn_ready
    );

endinterface

// File: rtl/insn_fetch_sequencer.sv
// Fetch sequencer: opcode pop, ROM classify, ModRM hand-off, immediate
// collection and record handshake. Optional macro PREFIX_EN: segment prefixes.
module insn_fetch_sequencer
    import insn_fetch_sequencer_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                flush,
    output logic                fifo_rd_en,
    input  logic [7:0]          fifo_rd_data,
    input  logic                fifo_empty,
    output logic                modrm_start,
    input  logic                modrm_fifo_rd_en,
    input  logic                modrm_complete,
    output logic [7:0]          rom_opcode,
    input  logic                rom_has_modrm,
    input  logic [1:0]          rom_imm_bytes,
    insn_fetch_sequencer_if.master insn
);

    fsm_state_e       state_q, state_d;
    logic [7:0]       opcode_q, opcode_d;
    logic             has_modrm_q, has_modrm_d;
    imm_cnt_t         imm_bytes_q, imm_bytes_d;
    logic [IMM_W-1:0] imm_q, imm_d;
    imm_cnt_t         pop_cnt_q, pop_cnt_d;
    imm_cnt_t         st_cnt_q, st_cnt_d;
    logic             popped_q, popped_d;
`ifdef PREFIX_EN
    logic             seg_valid_q, seg_valid_d;
    seg_e             seg_q, seg_d;
`endif

    logic     rd_req;
    logic     start_req;
    imm_cnt_t rom_imm_c;

    assign rom_imm_c = clamp_imm(rom_imm_bytes);

    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        has_modrm_d = has_modrm_q;
        imm_bytes_d = imm_bytes_q;
        imm_d       = imm_q;
        pop_cnt_d   = pop_cnt_q;
        st_cnt_d    = st_cnt_q;
        popped_d    = 1'b0;
        rd_req      = 1'b0;
        start_req   = 1'b0;
`ifdef PREFIX_EN
        seg_valid_d = seg_valid_q;
        seg_d       = seg_q;
`endif

        unique case (state_q)
            FETCH_OP: begin
                if (!fifo_empty) begin
                    rd_req  = 1'b1;
                    state_d = WAIT_OP;
                end
            end

            WAIT_OP: begin
`ifdef PREFIX_EN
                if (is_seg_prefix(fifo_rd_data)) begin
                    seg_valid_d = 1'b1;
                    seg_d       = prefix_seg(fifo_rd_data);
                    state_d     = FETCH_OP;
                end else begin
                    opcode_d = fifo_rd_data;
                    state_d  = CLASSIFY;
                end
`else
                opcode_d = fifo_rd_data;
                state_d  = CLASSIFY;
`endif
            end

            CLASSIFY: begin
                has_modrm_d = rom_has_modrm;
                imm_bytes_d = rom_imm_c;
                imm_d       = '0;
                pop_cnt_d   = '0;
                st_cnt_d    = '0;
                // The decoder pops its ModRM byte in the start cycle
                if (rom_has_modrm) begin
                    start_req = 1'b1;
                    rd_req    = modrm_fifo_rd_en;
                    state_d   = MODRM;
                end else if (rom_imm_c != '0) begin
                    state_d = IMM;
                end else begin
                    state_d = DONE;
                end
            end

            MODRM: begin
                rd_req = modrm_fifo_rd_en;
                if (modrm_complete) begin
                    state_d = (imm_bytes_q != '0) ? IMM : DONE;
                end
            end

            IMM: begin
                if (popped_q) begin
                    if (st_cnt_q == '0) begin
                        imm_d[7:0] = fifo_rd_data;
                    end else begin
                        imm_d[15:8] = fifo_rd_data;
                    end
                    st_cnt_d = st_cnt_q + imm_cnt_t'(1);
                    if ((st_cnt_q + imm_cnt_t'(1)) == imm_bytes_q) begin
                        state_d = DONE;
                    end
                end
                if ((pop_cnt_q < imm_bytes_q) && !fifo_empty) begin
                    rd_req    = 1'b1;
                    pop_cnt_d = pop_cnt_q + imm_cnt_t'(1);
                    popped_d  = 1'b1;
                end
            end

            DONE: begin
                if (insn.insn_ready) begin
                    state_d   = FETCH_OP;
                    pop_cnt_d = '0;
                    st_cnt_d  = '0;
`ifdef PREFIX_EN
                    seg_valid_d = 1'b0;
                    seg_d       = SEG_ES;
`endif
                end
            end

            default: state_d = FETCH_OP;
        endcase

        // Abort wins over everything, including a same-cycle handshake
        if (flush) begin
            state_d   = FETCH_OP;
            imm_d     = '0;
            pop_cnt_d = '0;
            st_cnt_d  = '0;
            popped_d  = 1'b0;
            rd_req    = 1'b0;
            start_req = 1'b0;
`ifdef PREFIX_EN
            seg_valid_d = 1'b0;
            seg_d       = SEG_ES;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= FETCH_OP;
            opcode_q    <= '0;
            has_modrm_q <= 1'b0;
            imm_bytes_q <= '0;
            imm_q       <= '0;
            pop_cnt_q   <= '0;
            st_cnt_q    <= '0;
            popped_q    <= 1'b0;
`ifdef PREFIX_EN
            seg_valid_q <= 1'b0;
            seg_q       <= SEG_ES;
`endif
        end else begin
            state_q     <= state_d;
            opcode_q    <= opcode_d;
            has_modrm_q <= has_modrm_d;
            imm_bytes_q <= imm_bytes_d;
            imm_q       <= imm_d;
            pop_cnt_q   <= pop_cnt_d;
            st_cnt_q    <= st_cnt_d;
            popped_q    <= popped_d;
`ifdef PREFIX_EN
            seg_valid_q <= seg_valid_d;
            seg_q       <= seg_d;
`endif
        end
    end

    // Reset gating keeps the pop/start strobes low while reset is held
    assign fifo_rd_en  = rd_req & ~fifo_empty & reset_n;
    assign modrm_start = start_req & reset_n;
    assign rom_opcode  = opcode_q;

    assign insn.insn_valid     = (state_q == DONE);
    assign insn.insn_opcode    = opcode_q;
    assign insn.insn_has_modrm = has_modrm_q;
    assign insn.insn_imm       = imm_q;
    assign insn.insn_imm_bytes = imm_bytes_q;
`ifdef PREFIX_EN
    assign insn.insn_seg_valid = seg_valid_q;
    assign insn.insn_seg       = seg_q;
`endif

endmodule

// File: tb/tb_insn_fetch_sequencer.sv
// Scoreboard bench for insn_fetch_sequencer with FIFO, ROM and ModRM models.
// Prefix checks are compiled in when PREFIX_EN is defined.
module tb_insn_fetch_sequencer;
    import insn_fetch_sequencer_pkg::*;

    typedef struct packed {
        logic [7:0]  op;
        logic        hm;
        logic [15:0] imm;
        logic [1:0]  nb;
        logic        sv;
        logic [1:0]  sg;
    } rec_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       flush = 1'b0;
    logic       fifo_rd_en;
    logic [7:0] fifo_rd_data = 8'h00;
    logic       fifo_empty;
    logic       modrm_start;
    logic       modrm_fifo_rd_en;
    logic       modrm_complete;
    logic [7:0] rom_opcode;
    logic       rom_has_modrm;
    logic [1:0] rom_imm_bytes;
    logic       ready = 1'b1;
    logic       rom_m = 1'b0;
    logic [1:0] rom_i = 2'd0;
    logic       spur = 1'b0;
    logic       fifo_clr = 1'b0;

    int   checks = 0;
    int   errors = 0;
    rec_t exp_q[$];

    logic [7:0] mem [0:255];
    int   wr_ptr = 0;
    int   rd_ptr = 0;
    int   pops = 0;
    int   mr_ph = 0;
    int   mr_disp = 0;

    always #5 clk = ~clk;

    insn_fetch_sequencer_if u_if ();
    assign u_if.insn_ready = ready;

    insn_fetch_sequencer dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .flush            (flush),
        .fifo_rd_en       (fifo_rd_en),
        .fifo_rd_data     (fifo_rd_data),
        .fifo_empty       (fifo_empty),
        .modrm_start      (modrm_start),
        .modrm_fifo_rd_en (modrm_fifo_rd_en),
        .modrm_complete   (modrm_complete),
        .rom_opcode       (rom_opcode),
        .rom_has_modrm    (rom_has_modrm),
        .rom_imm_bytes    (rom_imm_bytes),
        .insn             (u_if)
    );

    // Prefetch FIFO: data appears the cycle after a pop
    assign fifo_empty = (rd_ptr == wr_ptr);
    always_ff @(posedge clk) begin
        if (fifo_clr) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_rd_en) begin
            if (rd_ptr != wr_ptr) begin
                fifo_rd_data <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1;
            end
            pops <= pops + 1;
        end
    end

    assign rom_has_modrm = rom_m;
    assign rom_imm_bytes = rom_i;

    // ModRM decoder: pops on start, then mr_disp more bytes, then completes
    always_ff @(posedge clk) begin
        if (modrm_start) begin
            mr_ph <= 1;
        end else if (mr_ph != 0) begin
            mr_ph <= (mr_ph == mr_disp + 1) ? 0 : mr_ph + 1;
        end
    end
    assign modrm_fifo_rd_en = modrm_start | spur |
                              ((mr_ph >= 1) && (mr_ph <= mr_disp));
    assign modrm_complete   = (mr_ph != 0) && (mr_ph == mr_disp + 1);

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr[7:0]] = b;
        wr_ptr++;
    endtask

    task automatic expect_rec(input logic [7:0] op, input logic hm,
                              input logic [15:0] imm, input logic [1:0] nb,
                              input logic sv, input logic [1:0] sg);
        rec_t r;
        r.op = op; r.hm = hm; r.imm = imm; r.nb = nb;
        r.sv = sv; r.sg = sg;
        exp_q.push_back(r);
    endtask

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!u_if.insn_valid && n < 60);
        if (!u_if.insn_valid) begin
            chk("valid_timeout", 32'(u_if.insn_valid), 32'd1);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((u_if.insn_valid || exp_q.size() != 0) && n < 100);
        if (n >= 100) begin
            chk("idle_timeout", 32'(exp_q.size()), 32'd0);
        end
    endtask

    // Record monitor
    initial begin
        rec_t act;
        rec_t req;
        forever begin
            @(negedge clk);
            if (u_if.insn_valid && ready && !flush) begin
                act.op  = u_if.insn_opcode;
                act.hm  = u_if.insn_has_modrm;
                act.imm = u_if.insn_imm;
                act.nb  = u_if.insn_imm_bytes;
`ifdef PREFIX_EN
                act.sv  = u_if.insn_seg_valid;
                act.sg  = 2'(u_if.insn_seg);
`else
                act.sv  = 1'b0;
                act.sg  = 2'd0;
`endif
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rec_unexpected: got %0h expected none",
                             act);
                end else begin
                    req = exp_q.pop_front();
                    if (act !== req) begin
                        errors++;
                        $display("FAIL rec: got %0h expected %0h", act, req);
                    end
                end
            end
        end
    end

    // Pop on empty must never happen
    initial begin
        forever begin
            @(negedge clk);
            checks++;
            if (fifo_rd_en && fifo_empty) begin
                errors++;
                $display("FAIL rd_en_empty: got 1 expected 0");
            end
        end
    end

    initial begin
        int n;
        int p;
        int starts;
        int mm;
        int tc;
        int tv;
        int bad;
        rec_t snap;
        rec_t cur;

        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("rst_valid", 32'(u_if.insn_valid), 32'd0);
        chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("rst_start", 32'(modrm_start), 32'd0);
        chk("rst_opcode", 32'(u_if.insn_opcode), 32'd0);
        chk("rst_imm", 32'(u_if.insn_imm), 32'd0);

        // Opcode-only: valid in the 4th cycle counting the pop cycle
        drive_edge();
        rom_m = 1'b0; rom_i = 2'd0;
        p = pops;
        push(8'h90);
        expect_rec(8'h90, 1'b0, 16'h0000, 2'd0, 1'b0, 2'd0);
        wait_valid(n);
        chk("nop_latency", 32'(n), 32'd4);
        chk("nop_rom_op", 32'(rom_opcode), 32'h90);
        wait_idle();
        chk("nop_pops", 32'(pops - p), 32'd1);

        // Two-byte immediate with an empty FIFO between bytes
        drive_edge();
        rom_m = 1'b0; rom_i = 2'd2;
        p = pops;
        push(8'hB8); push(8'h34);
        expect_rec(8'hB8, 1'b0, 16'h1234, 2'd2, 1'b0, 2'd0);
        repeat (8) @(negedge clk);
        chk("stall_novalid", 32'(u_if.insn_valid), 32'd0);
        chk("stall_pops", 32'(pops - p), 32'd2);
        drive_edge();
        push(8'h12);
        wait_valid(n);
        wait_idle();
        chk("imm2_pops", 32'(pops - p), 32'd3);

        // ModRM with one displacement byte
        drive_edge();
        rom_m = 1'b1; rom_i = 2'd0; mr_disp = 1;
        p = pops;
        push(8'h8B); push(8'hC0); push(8'h05);
        expect_rec(8'h8B, 1'b1, 16'h0000, 2'd0, 1'b0, 2'd0);
        starts = 0; mm = 0; tc = -1; tv = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (modrm_start) starts++;
            if (starts > 0 && !u_if.insn_valid &&
                fifo_rd_en !== modrm_fifo_rd_en) mm++;
            if (modrm_complete && tc < 0) tc = i;
            if (u_if.insn_valid) begin
                tv = i;
                break;
            end
        end
        chk("modrm_start_once", 32'(starts), 32'd1);
        chk("modrm_mirror", 32'(mm), 32'd0);
        chk("modrm_valid_lat", 32'(tv), 32'(tc + 1));
        wait_idle();
        chk("modrm_pops", 32'(pops - p), 32'd3);
        mr_disp = 0;

        // ModRM plus immediates, then illegal length 3 treated as 2
        drive_edge();
        rom_m = 1'b1; rom_i = 2'd2;
        push(8'h81); push(8'hC3); push(8'hFF); push(8'h00);
        expect_rec(8'h81, 1'b1, 16'h00FF, 2'd2, 1'b0, 2'd0);
        wait_idle();
        drive_edge();
        rom_m = 1'b1; rom_i = 2'd1;
        push(8'h83); push(8'hC3); push(8'h80);
        expect_rec(8'h83, 1'b1, 16'h0080, 2'd1, 1'b0, 2'd0);
        wait_idle();
        drive_edge();
        rom_m = 1'b0; rom_i = 2'd3;
        p = pops;
        push(8'hC2); push(8'hAA); push(8'hBB);
        expect_rec(8'hC2, 1'b0, 16'hBBAA, 2'd2, 1'b0, 2'd0);
        wait_idle();
        chk("imm3_pops", 32'(pops - p), 32'd3);

        // Back-pressure: record held, no pops, decoder requests masked
        drive_edge();
        rom_m = 1'b0; rom_i = 2'd0; ready = 1'b0;
        push(8'h40); push(8'h41);
        expect_rec(8'h40, 1'b0, 16'h0000, 2'd0, 1'b0, 2'd0);
        expect_rec(8'h41, 1'b0, 16'h0000, 2'd0, 1'b0, 2'd0);
        wait_valid(n);
        drive_edge();
        snap = {u_if.insn_opcode, u_if.insn_has_modrm, u_if.insn_imm,
                u_if.insn_imm_bytes, 3'b000};
        p = pops;
        spur = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            cur = {u_if.insn_opcode, u_if.insn_has_modrm, u_if.insn_imm,
                   u_if.insn_imm_bytes, 3'b000};
            if (!u_if.insn_valid || cur !== snap) bad++;
        end
        chk("hold_stable", 32'(bad), 32'd0);
        chk("hold_nopop", 32'(pops - p), 32'd0);
        drive_edge();
        spur = 1'b0; ready = 1'b1;
        wait_idle();

        // Flush concurrent with a handshake drops the record
        drive_edge();
        ready = 1'b0;
        p = pops;
        push(8'h50);
        wait_valid(n);
        drive_edge();
        ready = 1'b1; flush = 1'b1;
        drive_edge();
        flush = 1'b0;
        @(negedge clk);
        chk("flush_drop", 32'(u_if.insn_valid), 32'd0);
        wait_idle();
        chk("flush_drop_pops", 32'(pops - p), 32'd1);

        // Flush in IMM after one byte; next record uses only new bytes
        drive_edge();
        rom_m = 1'b0; rom_i = 2'd2;
        p = pops;
        push(8'hB8); push(8'h11);
        repeat (6) @(negedge clk);
        chk("pre_flush_pops", 32'(pops - p), 32'd2);
        drive_edge();
        push(8'hB8); push(8'h22); push(8'h33);
        flush = 1'b1;
        expect_rec(8'hB8, 1'b0, 16'h3322, 2'd2, 1'b0, 2'd0);
        @(negedge clk);
        chk("flush_rd_en", 32'(fifo_rd_en), 32'd0);
        drive_edge();
        flush = 1'b0;
        wait_idle();
        chk("flush_imm_pops", 32'(pops - p), 32'd5);

`ifdef PREFIX_EN
        drive_edge();
        rom_m = 1'b1; rom_i = 2'd0;
        push(8'h2E); push(8'h8B); push(8'hC0);
        expect_rec(8'h8B, 1'b1, 16'h0000, 2'd0, 1'b1, 2'd1);
        wait_idle();
        drive_edge();
        rom_m = 1'b0; rom_i = 2'd0;
        push(8'h26); push(8'h36); push(8'h90); push(8'h91);
        expect_rec(8'h90, 1'b0, 16'h0000, 2'd0, 1'b1, 2'd2);
        expect_rec(8'h91, 1'b0, 16'h0000, 2'd0, 1'b0, 2'd0);
        wait_idle();
`else
        drive_edge();
        rom_m = 1'b0; rom_i = 2'd0;
        push(8'h2E);
        expect_rec(8'h2E, 1'b0, 16'h0000, 2'd0, 1'b0, 2'd0);
        wait_idle();
`endif

        // Asynchronous reset while the decoder owns the pop port
        drive_edge();
        rom_m = 1'b1; rom_i = 2'd0; mr_disp = 3;
        push(8'h8B); push(8'hC0); push(8'hD1); push(8'hD2); push(8'hD3);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!modrm_start && n < 40);
        chk("rst_mr_started", 32'(modrm_start), 32'd1);
        @(negedge clk);
        @(negedge clk);
        chk("rst_mr_rd_pre", 32'(fifo_rd_en), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_async_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("rst_async_start", 32'(modrm_start), 32'd0);
        chk("rst_async_op", 32'(u_if.insn_opcode), 32'd0);
        fifo_clr = 1'b1;
        drive_edge();
        fifo_clr = 1'b0;
        repeat (6) @(posedge clk);
        #1 reset_n = 1'b1;
        mr_disp = 0;
        @(negedge clk);
        chk("rst_post_valid", 32'(u_if.insn_valid), 32'd0);
        chk("rst_post_rd_en", 32'(fifo_rd_en), 32'd0);

        wait_idle();
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
